// File: rtl/elevator_pkg.sv
// Shared elevator controller definitions: floor codes, direction codes and the
// door state encoding used by the call request unit.
package elevator_pkg;

    localparam logic [1:0] FL1    = 2'b00;
    localparam logic [1:0] FL2    = 2'b01;
    localparam logic [1:0] FL3    = 2'b10;
    localparam logic [1:0] FL_INV = 2'b11;

    localparam logic [1:0] De = 2'b00;
    localparam logic [1:0] Su = 2'b01;
    localparam logic [1:0] Pa = 2'b10;

    typedef enum logic {
        CLOSED = 1'b0,
        OPEN   = 1'b1
    } door_state_e;

endpackage

// File: rtl/call_request_unit_if.sv
// Button, position and call/door signals between the call request unit and its
// surroundings (buttons, floor sensor, direction logic).
interface call_request_unit_if;

    logic       B1;
    logic       B2;
    logic       B3;
    logic [1:0] A;
    logic       MM;
    logic       CH1;
    logic       CH2;
    logic       CH3;
    logic       DOOR;
    logic       HOLD;

    modport master (
        output B1, B2, B3, A, MM,
        input  CH1, CH2, CH3, DOOR, HOLD
    );

    modport slave (
        input  B1, B2, B3, A, MM,
        output CH1, CH2, CH3, DOOR, HOLD
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw button; emits a
// single-cycle pulse on each accepted press (debounced rising edge).
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            level_dly_q;

    // Any sample agreeing with the accepted level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn};
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/call_request_unit.sv
// Registers floor calls from debounced buttons, services the call at the parked
// floor and runs the door dwell; HOLD keeps the car stopped while the door is open.
module call_request_unit
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DWELL_CYCLES    = 50000000
) (
    input  logic         clk,
    input  logic         rst_n,
    call_request_unit_if.slave bus
);

    localparam int unsigned DwellW = $clog2(DWELL_CYCLES);

    logic [2:0]        press;
    logic [2:0]        here_mask;
    logic [2:0]        ch_q, ch_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    door_state_e       state_q, state_d;
    logic              parked, here_press, here_call, service;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clk(clk), .rst_n(rst_n), .btn(bus.B1), .press(press[0])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
        .clk(clk), .rst_n(rst_n), .btn(bus.B2), .press(press[1])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb3 (
        .clk(clk), .rst_n(rst_n), .btn(bus.B3), .press(press[2])
    );

    // One-hot of the current floor; empty for the invalid code so it never services.
    always_comb begin
        here_mask = 3'b000;
        case (bus.A)
            FL1:     here_mask = 3'b001;
            FL2:     here_mask = 3'b010;
            FL3:     here_mask = 3'b100;
            default: here_mask = 3'b000;
        endcase
    end

    assign parked     = ~bus.MM & (bus.A != FL_INV);
    assign here_press = |(press & here_mask);
    assign here_call  = |(ch_q & here_mask);

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        service = 1'b0;
        case (state_q)
            CLOSED: begin
                if (parked && (here_call || here_press)) begin
                    state_d = OPEN;
                    dwell_d = DwellW'(DWELL_CYCLES - 1);
                    service = 1'b1;
                end
            end
            OPEN: begin
                service = 1'b1;
                if (here_press) begin
                    dwell_d = DwellW'(DWELL_CYCLES - 1);
                end else if (dwell_q == '0) begin
                    state_d = CLOSED;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            default: state_d = CLOSED;
        endcase
        // Servicing the current floor overrides a same-cycle press for it.
        ch_d = (ch_q | press) & ~(service ? here_mask : 3'b000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLOSED;
            dwell_q <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            ch_q    <= ch_d;
        end
    end

    assign bus.CH1  = ch_q[0];
    assign bus.CH2  = ch_q[1];
    assign bus.CH3  = ch_q[2];
    assign bus.DOOR = (state_q == OPEN);
    assign bus.HOLD = (state_q == OPEN);

endmodule

// File: tb/tb_call_request_unit.sv
// Directed bench for call_request_unit with DEBOUNCE_CYCLES = 4, DWELL_CYCLES = 8.
module tb_call_request_unit;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    call_request_unit_if bus ();

    call_request_unit #(
        .DEBOUNCE_CYCLES(4),
        .DWELL_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_b(input logic [2:0] v);
        bus.B1 = v[0];
        bus.B2 = v[1];
        bus.B3 = v[2];
    endtask

    // Clean press: accepted on sample 6, call registered on the 7th edge, then released.
    task automatic press_btn(input logic [2:0] v);
        set_b(v);
        step(6);
        set_b(3'b000);
        step(8);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_b(3'b000);
        bus.A  = 2'b11;
        bus.MM = 1'b1;
        step(3);
        check_eq("rst_ch1", bus.CH1, 1'b0);
        check_eq("rst_ch2", bus.CH2, 1'b0);
        check_eq("rst_ch3", bus.CH3, 1'b0);
        check_eq("rst_door", bus.DOOR, 1'b0);
        check_eq("rst_hold", bus.HOLD, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Bouncy B2: 3-cycle glitches must not be accepted.
        set_b(3'b010); step(3);
        set_b(3'b000); step(3);
        set_b(3'b010); step(3);
        set_b(3'b000); step(1);
        check_eq("bounce_ch2", bus.CH2, 1'b0);
        set_b(3'b010);
        step(6);
        check_eq("b2_ch2_early", bus.CH2, 1'b0);
        step(1);
        check_eq("b2_ch2_set", bus.CH2, 1'b1);
        check_eq("b2_ch1", bus.CH1, 1'b0);
        check_eq("b2_ch3", bus.CH3, 1'b0);
        check_eq("b2_door", bus.DOOR, 1'b0);
        set_b(3'b000);
        step(10);
        check_eq("b2_ch2_held", bus.CH2, 1'b1);

        // Service CH3 at floor 3.
        press_btn(3'b100);
        check_eq("b3_ch3_set", bus.CH3, 1'b1);
        bus.A  = 2'b10;
        bus.MM = 1'b0;
        step(1);
        check_eq("f3_ch3_clr", bus.CH3, 1'b0);
        check_eq("f3_door", bus.DOOR, 1'b1);
        check_eq("f3_hold", bus.HOLD, 1'b1);
        step(7);
        check_eq("f3_door_last", bus.DOOR, 1'b1);
        step(1);
        check_eq("f3_door_closed", bus.DOOR, 1'b0);
        check_eq("f3_hold_closed", bus.HOLD, 1'b0);
        check_eq("f3_ch2_kept", bus.CH2, 1'b1);
        bus.MM = 1'b1;
        bus.A  = 2'b11;

        // Reload at floor 1 when a B1 press lands at dwell count 2.
        press_btn(3'b001);
        check_eq("b1_ch1_set", bus.CH1, 1'b1);
        bus.A  = 2'b00;
        bus.MM = 1'b0;
        set_b(3'b001);
        step(1);
        check_eq("f1_door", bus.DOOR, 1'b1);
        check_eq("f1_ch1_clr", bus.CH1, 1'b0);
        step(5);
        set_b(3'b000);
        step(3);
        check_eq("f1_reload_open", bus.DOOR, 1'b1);
        step(5);
        check_eq("f1_reload_last", bus.DOOR, 1'b1);
        check_eq("f1_ch1_stays", bus.CH1, 1'b0);
        step(1);
        check_eq("f1_closed", bus.DOOR, 1'b0);
        bus.MM = 1'b1;
        step(4);

        // Floor 2: service old CH2, then simultaneous B2 and B3.
        bus.A  = 2'b01;
        bus.MM = 1'b0;
        step(1);
        check_eq("f2_door", bus.DOOR, 1'b1);
        check_eq("f2_ch2_clr", bus.CH2, 1'b0);
        step(8);
        check_eq("f2_closed", bus.DOOR, 1'b0);
        set_b(3'b110);
        step(6);
        check_eq("f2_pre_open", bus.DOOR, 1'b0);
        set_b(3'b000);
        step(1);
        check_eq("f2_press_open", bus.DOOR, 1'b1);
        check_eq("f2_ch2_not_set", bus.CH2, 1'b0);
        check_eq("f2_ch3_set", bus.CH3, 1'b1);
        step(9);
        check_eq("f2_reclosed", bus.DOOR, 1'b0);
        bus.MM = 1'b1;

        // Invalid floor code never opens the door.
        bus.A  = 2'b11;
        bus.MM = 1'b0;
        press_btn(3'b001);
        check_eq("inv_ch1_set", bus.CH1, 1'b1);
        step(10);
        check_eq("inv_door", bus.DOOR, 1'b0);
        check_eq("inv_ch1_held", bus.CH1, 1'b1);

        // Asynchronous reset mid-dwell.
        bus.A = 2'b01;
        set_b(3'b010);
        step(6);
        set_b(3'b000);
        step(1);
        check_eq("rd_door", bus.DOOR, 1'b1);
        step(3);
        check_eq("rd_ch1", bus.CH1, 1'b1);
        check_eq("rd_ch3", bus.CH3, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_door", bus.DOOR, 1'b0);
        check_eq("ar_hold", bus.HOLD, 1'b0);
        check_eq("ar_ch1", bus.CH1, 1'b0);
        check_eq("ar_ch3", bus.CH3, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(12);
        check_eq("post_door", bus.DOOR, 1'b0);
        check_eq("post_ch1", bus.CH1, 1'b0);
        check_eq("post_ch2", bus.CH2, 1'b0);
        check_eq("post_ch3", bus.CH3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
